// File: rtl/data_write_pack.sv
// Byte-to-word packer: gathers three bytes into an 18-bit word and presents it with a write address.
// Optional padding-bit check is enabled by defining DATA_WRITE_PACK_PAD_CHECK_EN.
module data_write_pack #(
  parameter int ADDR_WIDTH = 10,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  byteValid,
  input  logic [7:0]            byteIn,
  output logic                  byteReady,
  input  logic                  flush,
  output logic                  wordValid,
  input  logic                  wordReady,
  output logic [17:0]           dataOut,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [1:0]            byteCycle,
  output logic                  addrWrap,
  output logic                  padError
);

  typedef enum logic [1:0] {BYTE0 = 2'd0, BYTE1 = 2'd1, BYTE2 = 2'd2} cycle_t;

  cycle_t                  state_reg, state_next;
  logic [15:0]             partial_reg;
  logic                    word_valid_reg, word_valid_next;
  logic [17:0]             data_out_reg;
  logic [ADDR_WIDTH-1:0]   write_addr_reg;
  logic                    addr_wrap_reg;
  logic                    accept, word_done, transfer;

  assign accept    = byteValid && byteReady;
  assign word_done = accept && (state_reg == BYTE2);
  assign transfer  = word_valid_reg && wordReady;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= BYTE0;
    else        state_reg <= state_next;
  end

  // Next-state logic: flush wins and never coincides with an accept
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = BYTE0;
    end else if (accept) begin
      case (state_reg)
        BYTE0:   state_next = BYTE1;
        BYTE1:   state_next = BYTE2;
        default: state_next = BYTE0;
      endcase
    end
  end

  // Output logic: the last byte needs a free (or freeing) output register
  always_comb begin
    byteReady = 1'b0;
    if (!flush) begin
      if (state_reg == BYTE2) byteReady = !word_valid_reg || wordReady;
      else                    byteReady = 1'b1;
    end
  end

  assign byteCycle = state_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          partial_reg[gi*8 +: 8] <= 8'h00;
        else if (flush)
          partial_reg[gi*8 +: 8] <= 8'h00;
        else if (accept && (state_reg == cycle_t'(gi)))
          partial_reg[gi*8 +: 8] <= byteIn;
      end
    end
  endgenerate

  // A completing word overrides a transfer so the output register refills without a bubble
  always_comb begin
    word_valid_next = word_valid_reg;
    if (word_done)     word_valid_next = 1'b1;
    else if (transfer) word_valid_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid_reg <= 1'b0;
      data_out_reg   <= 18'h0;
      write_addr_reg <= ADDR_WIDTH'(START_ADDR);
      addr_wrap_reg  <= 1'b0;
    end else begin
      word_valid_reg <= word_valid_next;
      addr_wrap_reg  <= transfer && (write_addr_reg == {ADDR_WIDTH{1'b1}});
      if (word_done) data_out_reg <= {byteIn[7:6], partial_reg};
      if (transfer)  write_addr_reg <= write_addr_reg + 1'b1;
    end
  end

  assign wordValid = word_valid_reg;
  assign dataOut   = data_out_reg;
  assign writeAddr = write_addr_reg;
  assign addrWrap  = addr_wrap_reg;

`ifdef DATA_WRITE_PACK_PAD_CHECK_EN
  logic pad_error_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         pad_error_reg <= 1'b0;
    else if (word_done && |byteIn[5:0]) pad_error_reg <= 1'b1;
  end

  assign padError = pad_error_reg;
`else
  logic unused_pad_bits;
  assign unused_pad_bits = ^byteIn[5:0];
  assign padError = 1'b0;
`endif

endmodule

// File: tb/tb_data_write_pack.sv
// Directed bench for data_write_pack: packing, backpressure, flush, address wrap, async reset, pad check.
module tb_data_write_pack;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          byteValid;
  logic [7:0]    byteIn;
  logic          byteReady;
  logic          flush;
  logic          wordValid;
  logic          wordReady;
  logic [17:0]   dataOut;
  logic [AW-1:0] writeAddr;
  logic [1:0]    byteCycle;
  logic          addrWrap;
  logic          padError;

  int checks = 0;
  int failures = 0;
  logic exp_pad;

  data_write_pack #(.ADDR_WIDTH(AW), .START_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .byteValid(byteValid), .byteIn(byteIn),
    .byteReady(byteReady), .flush(flush), .wordValid(wordValid),
    .wordReady(wordReady), .dataOut(dataOut), .writeAddr(writeAddr),
    .byteCycle(byteCycle), .addrWrap(addrWrap), .padError(padError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    byteValid = 1'b1;
    byteIn    = b;
    #1;
    check({tag, "_rdy"}, 32'(byteReady), 32'd1);
    tick();
    byteValid = 1'b0;
  endtask

  initial begin
`ifdef DATA_WRITE_PACK_PAD_CHECK_EN
    exp_pad = 1'b1;
`else
    exp_pad = 1'b0;
`endif
    rst_n = 1'b0; byteValid = 1'b0; byteIn = 8'h00; flush = 1'b0; wordReady = 1'b1;
    tick(); tick();
    check("rst_cycle", 32'(byteCycle), 32'd0);
    check("rst_valid", 32'(wordValid), 32'd0);
    check("rst_data",  32'(dataOut),   32'd0);
    check("rst_addr",  32'(writeAddr), 32'd0);
    check("rst_wrap",  32'(addrWrap),  32'd0);
    check("rst_pad",   32'(padError),  32'd0);
    rst_n = 1'b1;
    tick();

    // First word: 0x34 0x12 0xC0 -> 0x31234 at address 0
    send_byte(8'h34, "w0b0");
    check("w0b0_cycle", 32'(byteCycle), 32'd1);
    send_byte(8'h12, "w0b1");
    check("w0b1_valid", 32'(wordValid), 32'd0);
    send_byte(8'hC0, "w0b2");
    check("w0_valid", 32'(wordValid), 32'd1);
    check("w0_data",  32'(dataOut),   32'h31234);
    check("w0_addr",  32'(writeAddr), 32'd0);

    // Second word 0x78 0x56 0x40 -> 0x15678 at address 1; first word leaves during byte 0
    send_byte(8'h78, "w1b0");
    check("w1b0_valid", 32'(wordValid), 32'd0);
    check("w1b0_addr",  32'(writeAddr), 32'd1);
    send_byte(8'h56, "w1b1");
    send_byte(8'h40, "w1b2");
    check("w1_valid", 32'(wordValid), 32'd1);
    check("w1_data",  32'(dataOut),   32'h15678);
    check("w1_addr",  32'(writeAddr), 32'd1);

    // Backpressure: bytes 0/1 still accepted, byte 2 stalls
    wordReady = 1'b0;
    send_byte(8'h11, "bp_b0");
    send_byte(8'h22, "bp_b1");
    byteValid = 1'b1; byteIn = 8'h80;
    #1;
    check("bp_stall_rdy", 32'(byteReady), 32'd0);
    tick();
    check("bp_cycle", 32'(byteCycle), 32'd2);
    check("bp_valid", 32'(wordValid), 32'd1);
    check("bp_data",  32'(dataOut),   32'h15678);
    check("bp_addr",  32'(writeAddr), 32'd1);
    wordReady = 1'b1;
    #1;
    check("bp_release_rdy", 32'(byteReady), 32'd1);
    tick();
    byteValid = 1'b0;
    check("bp_nobubble_valid", 32'(wordValid), 32'd1);
    check("bp_nobubble_data",  32'(dataOut),   32'h22211);
    check("bp_nobubble_addr",  32'(writeAddr), 32'd2);

    // Flush discards 0xBBAA; next word 0x01 0x02 0x40 -> 0x10201 at address 3
    send_byte(8'hAA, "fl_b0");
    check("fl_b0_addr", 32'(writeAddr), 32'd3);
    send_byte(8'hBB, "fl_b1");
    flush = 1'b1; byteValid = 1'b1; byteIn = 8'hCC;
    #1;
    check("fl_rdy", 32'(byteReady), 32'd0);
    tick();
    flush = 1'b0; byteValid = 1'b0;
    check("fl_cycle", 32'(byteCycle), 32'd0);
    check("fl_valid", 32'(wordValid), 32'd0);
    send_byte(8'h01, "fw_b0");
    send_byte(8'h02, "fw_b1");
    send_byte(8'h40, "fw_b2");
    check("fw_data", 32'(dataOut),   32'h10201);
    check("fw_addr", 32'(writeAddr), 32'd3);
    check("fw_wrap_before", 32'(addrWrap), 32'd0);

    // Transfer at address 3 wraps to 0
    tick();
    check("wrap_addr",  32'(writeAddr), 32'd0);
    check("wrap_pulse", 32'(addrWrap),  32'd1);
    check("wrap_valid", 32'(wordValid), 32'd0);
    tick();
    check("wrap_pulse_end", 32'(addrWrap), 32'd0);

    // Fifth word lands at address 0, then stalls with a partial word behind it
    wordReady = 1'b0;
    send_byte(8'hFF, "w4b0");
    send_byte(8'hEE, "w4b1");
    send_byte(8'hC0, "w4b2");
    check("w4_data", 32'(dataOut),   32'h3EEFF);
    check("w4_addr", 32'(writeAddr), 32'd0);
    send_byte(8'h01, "pre_rst_b0");
    send_byte(8'h02, "pre_rst_b1");
    check("pre_rst_cycle", 32'(byteCycle), 32'd2);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cycle", 32'(byteCycle), 32'd0);
    check("arst_valid", 32'(wordValid), 32'd0);
    check("arst_data",  32'(dataOut),   32'd0);
    check("arst_addr",  32'(writeAddr), 32'd0);
    tick();
    rst_n = 1'b1;
    wordReady = 1'b1;
    tick(); tick(); tick();
    check("post_rst_valid", 32'(wordValid), 32'd0);
    check("post_rst_addr",  32'(writeAddr), 32'd0);

    // Padding bits in byte 2: 0x81 keeps [7:6]=10 and drops the rest
    send_byte(8'h05, "pd_b0");
    send_byte(8'h06, "pd_b1");
    send_byte(8'h81, "pd_b2");
    check("pd_data", 32'(dataOut),  32'h20605);
    check("pd_err",  32'(padError), 32'(exp_pad));
    send_byte(8'h07, "pd2_b0");
    send_byte(8'h08, "pd2_b1");
    send_byte(8'h00, "pd2_b2");
    check("pd2_data",      32'(dataOut),   32'h00807);
    check("pd2_addr",      32'(writeAddr), 32'd1);
    check("pd_err_sticky", 32'(padError),  32'(exp_pad));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
